// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM/IO bus between the instruction fetcher
// and the load/store buffer. Each request becomes one bus cycle per byte.
// Read bytes are assembled little-endian; store bytes are scattered the same way.
module mem_arbiter #(
  parameter int unsigned FETCH_BYTES = 4,
  parameter bit          LS_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        has_misbranch,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [2:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NBYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e              state_q,    state_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [CNT_W-1:0]    n_q,        n_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [DATA_W-1:0]   wdata_q,    wdata_d;
  logic                owner_ls_q, owner_ls_d;
  logic [DATA_W-1:0]   rdata_q,    rdata_d;
  logic [ADDR_W-1:0]   mem_a_q,    mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                mem_wr_q,   mem_wr_d;
  logic                if_done_q,  if_done_d;
  logic [DATA_W-1:0]   if_data_q,  if_data_d;
  logic                ls_done_q,  ls_done_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;

  logic                io_stall_c;
  logic                grant_ok_c;
  logic                pick_ls_c;
  logic                pick_if_c;
  logic [CNT_W-1:0]    ls_n_c;
  logic [CNT_W-1:0]    cnt_nxt_c;

  // A write to the UART window stalls while its tx buffer is full
  assign io_stall_c = (mem_a_q[17:16] == 2'b11) && io_buffer_full;

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q & rdy & ~io_stall_c;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

  // Arbitration: no grant while a done pulse is out or a flush is in progress
  always_comb begin
    grant_ok_c = !if_done_q && !ls_done_q && !has_misbranch;
    pick_ls_c  = ls_req && (LS_PRIORITY || !if_req);
    pick_if_c  = if_req && !pick_ls_c;
    case (ls_size)
      3'd1:    ls_n_c = CNT_W'(1);
      3'd2:    ls_n_c = CNT_W'(2);
      default: ls_n_c = CNT_W'(4);
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    owner_ls_d = owner_ls_q;
    rdata_d    = rdata_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_done_d  = if_done_q;
    if_data_d  = if_data_q;
    ls_done_d  = ls_done_q;
    ls_rdata_d = ls_rdata_q;
    cnt_nxt_c  = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        mem_wr_d  = 1'b0;
        if_done_d = 1'b0;
        ls_done_d = 1'b0;
        cnt_d     = '0;
        if (grant_ok_c && pick_ls_c) begin
          owner_ls_d = 1'b1;
          addr_d     = ls_addr;
          n_d        = ls_n_c;
          wdata_d    = ls_wdata;
          rdata_d    = '0;
          mem_a_d    = ls_addr;
          if (ls_we) begin
            state_d    = ST_WRITE;
            mem_dout_d = ls_wdata[7:0];
            mem_wr_d   = 1'b1;
          end else begin
            state_d = ST_READ;
          end
        end else if (grant_ok_c && pick_if_c) begin
          owner_ls_d = 1'b0;
          addr_d     = if_addr;
          n_d        = CNT_W'(FETCH_BYTES);
          rdata_d    = '0;
          mem_a_d    = if_addr;
          state_d    = ST_READ;
        end
      end

      ST_READ: begin
        if (has_misbranch) begin
          state_d = ST_IDLE;
          mem_a_d = '0;
          cnt_d   = '0;
        end else begin
          // Byte driven at count k-1 arrives on mem_din at count k
          for (int b = 0; b < int'(NBYTES); b++) begin
            if (CNT_W'(b + 1) == cnt_q) rdata_d[8*b +: 8] = mem_din;
          end
          if (cnt_q == n_q) begin
            state_d = ST_IDLE;
            mem_a_d = '0;
            cnt_d   = '0;
            if (owner_ls_q) begin
              ls_done_d  = 1'b1;
              ls_rdata_d = rdata_d;
            end else begin
              if_done_d = 1'b1;
              if_data_d = rdata_d;
            end
          end else begin
            cnt_d   = cnt_nxt_c;
            mem_a_d = (cnt_nxt_c < n_q) ? addr_q + ADDR_W'(cnt_nxt_c) : '0;
          end
        end
      end

      ST_WRITE: begin
        // Stores are committed, so a flush does not abort them
        if (!io_stall_c) begin
          if (cnt_nxt_c == n_q) begin
            state_d    = ST_IDLE;
            mem_wr_d   = 1'b0;
            mem_a_d    = '0;
            mem_dout_d = '0;
            ls_done_d  = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d   = cnt_nxt_c;
            mem_a_d = addr_q + ADDR_W'(cnt_nxt_c);
            for (int b = 0; b < int'(NBYTES); b++) begin
              if (CNT_W'(b) == cnt_nxt_c) mem_dout_d = wdata_q[8*b +: 8];
            end
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        mem_wr_d = 1'b0;
        mem_a_d  = '0;
      end
    endcase
  end

  // State and output registers; rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      owner_ls_q <= 1'b0;
      rdata_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      owner_ls_q <= owner_ls_d;
      rdata_q    <= rdata_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      if_data_q  <= if_data_d;
      ls_done_q  <= ls_done_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM/IO bus between two requesters: the instruction fetcher (4-byte reads) and the load/store buffer (1/2/4-byte reads and writes).
- Breaks each request into per-byte bus cycles and assembles or scatters little-endian words.
- Throttles writes to the I/O port on io_buffer_full.
- Aborts speculative reads on branch misprediction.

Parameters:
FETCH_BYTES, 4, bytes per instruction fetch
LS_PRIORITY, 1, 1 = load/store wins simultaneous requests in IDLE; 0 = fetch wins

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
has_misbranch  in  1  flush pulse from reorder buffer
io_buffer_full  in  1  UART tx buffer full
mem_din  in  8  RAM read byte; valid the cycle after its address is driven
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM address
mem_wr  out  1  1 = write this cycle
if_req  in  1  fetch request; held until if_done
if_addr  in  32  fetch address
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word, byte 0 in [7:0]
ls_req  in  1  load/store request; held until ls_done
ls_we  in  1  1 = store
ls_addr  in  32  byte address
ls_size  in  3  byte count: 1, 2 or 4
ls_wdata  in  32  store data, low ls_size bytes used
ls_done  out  1  one-cycle pulse
ls_rdata  out  32  load data, zero-extended little-endian

Behaviour:
- Reset: the state is IDLE, byte counter is 0, and every output (mem_a, mem_dout, mem_wr, if_done, if_data, ls_done, ls_rdata) is 0.
- rdy=0: all registers hold. mem_wr is gated to 0 combinationally, so no write repeats. Done pulses are not lost; they appear when rdy returns.
- States: IDLE, READ, WRITE.
- IDLE:
  - Samples requests only when neither done output is asserted this cycle. This prevents re-granting a request that is still held while done is high.
  - Picks a winner per LS_PRIORITY.
  - At grant, latches the address, byte count n (FETCH_BYTES for fetch, ls_size for load/store), write data and owner, then moves to READ or WRITE. Call the grant cycle G.
  - mem_wr=0 in IDLE.
- READ:
  - Byte i address (addr+i, 32-bit wrap) is driven on mem_a in cycle G+1+i.
  - mem_din in cycle G+2+i is written to result bits [8i+7:8i].
  - After byte n-1 is captured (end of G+n+1), the owner's done pulses in G+n+2 with data, and the state returns to IDLE.
  - Unused upper bytes of ls_rdata are 0.
- WRITE:
  - Byte i of wdata is driven on mem_dout with mem_a=addr+i and mem_wr=1, one byte per cycle.
  - No stall: bytes occupy G+1..G+n, and ls_done pulses in G+n+1.
  - I/O stall: if the byte address has bits [17:16]==2'b11 and io_buffer_full=1 in that cycle, drive mem_wr=0, hold the counter and retry next cycle.
- Misbranch (has_misbranch=1, rdy=1):
  - Any READ (fetch or load) aborts: next cycle IDLE, mem_wr=0, mem_a=0, no done pulse.
  - Requests presented in the misbranch cycle are not granted.
  - WRITE is never aborted (stores are committed) and completes normally with ls_done.
- Done outputs are registered. They are high exactly one rdy-active cycle, and if_done/ls_done are never high together.
- Simultaneous ls_req and if_req while busy: both wait. There is no pre-emption of an in-flight transfer.
- ls_size values other than 1, 2 or 4 are treated as 4.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → all outputs 0, mem_wr=0.
- Fetch: if_req=1, if_addr=0x1000; RAM 0x1000..0x1003 = 13,00,00,93 → mem_a=0x1000..0x1003 in G+1..G+4; if_done in G+6 with if_data=0x93000013.
- Contention, LS_PRIORITY=1: if_req and ls_req (load, size 2, addr 0x20) rise in the same IDLE cycle, RAM 0x20,0x21 = 0xFF,0x80 → load served first, ls_rdata=0x000080FF at G+4. The fetch is then granted at G+5 (G+4 is a done cycle, so no grant there).
- Store to UART: ls_we=1, ls_addr=0x30000, ls_size=1, ls_wdata=0x41, io_buffer_full=1 for 3 cycles → mem_wr stays 0 for 3 cycles, then exactly one cycle of mem_wr=1 with mem_dout=0x41, followed by ls_done.
- Misbranch mid-fetch: has_misbranch=1 at G+3 of a fetch → IDLE at G+4, no if_done ever. A store in progress under the same pulse still writes all 4 bytes and asserts ls_done.
- rdy freeze: rdy=0 for 5 cycles during the third byte of a 4-byte store → mem_wr=0 throughout, the counter holds, the remaining bytes resume on rdy=1, and total bytes written = 4.
